// File: rtl/cpu_tx_if.sv
// cpu_tx_if: valid/ready payload channel from a CPU traffic generator toward the NOC.
interface cpu_tx_if;
    logic        data_vld;
    logic        data_rdy;
    logic [63:0] data;
    modport master (output data_vld, data, input data_rdy);
    modport slave  (input data_vld, data, output data_rdy);
endinterface

// File: rtl/cpu_tx.sv
// cpu_tx: emits TRANSACTION_NB sequenced payloads per run through a small FIFO toward the NOC.
module cpu_tx #(
    parameter int          CPU_IDX        = 0,
    parameter int unsigned TRANSACTION_NB = 10,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          GAP_CYCLES     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    cpu_tx_if.master      noc,
    output logic          busy,
    output logic          done,
    output logic [31:0]   sent_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t      state_q, state_d;
    logic [63:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0] gen_q, gen_d, sent_q, sent_d, gap_q, gap_d;
    logic        empty, full, push, pop, go;
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        go      = start && (state_q == IDLE || state_q == DONE);
        push    = state_q == RUN && gen_q < 32'(TRANSACTION_NB) && !full && gap_q == 0;
        pop     = !empty && noc.data_rdy;
        state_d = state_q;
        gen_d   = gen_q + {31'd0, push};
        sent_d  = sent_q + {31'd0, pop};
        wr_d    = wr_q + {{AW{1'b0}}, push};
        rd_d    = rd_q + {{AW{1'b0}}, pop};
        gap_d   = push ? 32'(GAP_CYCLES) : (gap_q != 0 ? gap_q - 32'd1 : gap_q);
        if (state_q == RUN && gen_q == 32'(TRANSACTION_NB))
            state_d = DRAIN;
        if (state_q == DRAIN && empty)
            state_d = DONE;
        if (go) begin
            state_d = RUN;
            gen_d   = '0;
            sent_d  = '0;
            gap_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gen_q   <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            if (push) mem_q[wr_q[AW-1:0]] <= {8'(CPU_IDX), 8'hA5, 16'h0000, gen_q};
        end
    end
    // No bypass: valid only reflects what is already stored.
    assign noc.data_vld = !empty;
    assign noc.data     = mem_q[rd_q[AW-1:0]];
    assign busy         = state_q == RUN || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign sent_count   = sent_q;
endmodule

// File: tb/tb_cpu_tx.sv
// tb_cpu_tx: directed checks of cpu_tx over several parameterisations.
module tb_cpu_tx;
    logic clk = 0, rst_n = 1;
    logic st0 = 0, st1 = 0, st2 = 0, st3 = 0;
    logic busy0, done0, busy1, done1, busy2, done2, busy3, done3;
    logic [31:0] cnt0, cnt1, cnt2, cnt3;
    int n_chk = 0, n_fail = 0;
    cpu_tx_if i0(), i1(), i2(), i3();
    always #5 clk = ~clk;
    cpu_tx #(.CPU_IDX(3), .TRANSACTION_NB(10), .FIFO_DEPTH(4), .GAP_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .start(st0), .noc(i0.master), .busy(busy0), .done(done0), .sent_count(cnt0));
    cpu_tx #(.CPU_IDX(7), .TRANSACTION_NB(1000), .FIFO_DEPTH(4), .GAP_CYCLES(0)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .noc(i1.master), .busy(busy1), .done(done1), .sent_count(cnt1));
    cpu_tx #(.CPU_IDX(2), .TRANSACTION_NB(6), .FIFO_DEPTH(4), .GAP_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .start(st2), .noc(i2.master), .busy(busy2), .done(done2), .sent_count(cnt2));
    cpu_tx #(.CPU_IDX(9), .TRANSACTION_NB(0), .FIFO_DEPTH(2), .GAP_CYCLES(0)) u3 (.clk(clk), .rst_n(rst_n), .start(st3), .noc(i3.master), .busy(busy3), .done(done3), .sent_count(cnt3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pl(input logic [7:0] c, input int s);
        return {c, 8'hA5, 16'h0000, s[31:0]};
    endfunction

    task automatic test_reset;
        i0.data_rdy = 0; i1.data_rdy = 0; i2.data_rdy = 0; i3.data_rdy = 0;
        #2 rst_n = 0;
        #1;
        n_chk++; if (i0.data_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", i0.data_vld); end
        n_chk++; if (i0.data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", i0.data); end
        n_chk++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {busy0, done0}); end
        n_chk++; if (cnt0 !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt0); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        st0 = 0;
        tick;
        n_chk++; if ({busy0, done0, i0.data_vld} !== 3'b000) begin n_fail++; $display("FAIL reset_idle got %b want 000", {busy0, done0, i0.data_vld}); end
    endtask

    task automatic test_basic;
        i0.data_rdy = 1;
        st0 = 1; tick; st0 = 0;
        n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy0); end
        n_chk++; if (i0.data_vld !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got %b want 0", i0.data_vld); end
        tick;
        for (int i = 0; i < 10; i++) begin
            n_chk++; if (i0.data_vld !== 1'b1 || i0.data !== pl(3, i)) begin n_fail++; $display("FAIL basic_payload%0d got %b/%h want 1/%h", i, i0.data_vld, i0.data, pl(3, i)); end
            tick;
        end
        n_chk++; if (i0.data_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_after got %b want 0", i0.data_vld); end
        for (int k = 0; k < 5 && done0 !== 1'b1; k++) tick;
        n_chk++; if (done0 !== 1'b1 || cnt0 !== 32'd10) begin n_fail++; $display("FAIL basic_done got %b/%0d want 1/10", done0, cnt0); end
        repeat (3) tick;
        n_chk++; if ({done0, i0.data_vld, cnt0} !== {2'b10, 32'd10}) begin n_fail++; $display("FAIL basic_hold_done got %b/%b/%0d want 1/0/10", done0, i0.data_vld, cnt0); end
    endtask

    task automatic test_stall;
        i0.data_rdy = 0;
        st0 = 1; tick; st0 = 0;
        tick;
        for (int k = 0; k < 20; k++) begin
            n_chk++; if (i0.data_vld !== 1'b1 || i0.data !== pl(3, 0)) begin n_fail++; $display("FAIL stall_hold%0d got %b/%h want 1/%h", k, i0.data_vld, i0.data, pl(3, 0)); end
            tick;
        end
        n_chk++; if (u0.gen_q !== 32'd4 || cnt0 !== 32'd0) begin n_fail++; $display("FAIL stall_pushes got %0d/%0d want 4/0", u0.gen_q, cnt0); end
        i0.data_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 5 && i0.data_vld !== 1'b1; k++) tick;
            n_chk++; if (i0.data_vld !== 1'b1 || i0.data !== pl(3, i)) begin n_fail++; $display("FAIL stall_drain%0d got %b/%h want 1/%h", i, i0.data_vld, i0.data, pl(3, i)); end
            tick;
        end
        for (int k = 0; k < 5 && done0 !== 1'b1; k++) tick;
        n_chk++; if (done0 !== 1'b1 || cnt0 !== 32'd10) begin n_fail++; $display("FAIL stall_done got %b/%0d want 1/10", done0, cnt0); end
    endtask

    task automatic test_random;
        int exp_seq = 0;
        logic stalled = 0;
        logic [63:0] held = '0;
        i1.data_rdy = 0;
        st1 = 1; tick; st1 = 0;
        for (int c = 0; c < 6000 && done1 !== 1'b1; c++) begin
            if (stalled) begin
                n_chk++; if (i1.data_vld !== 1'b1 || i1.data !== held) begin n_fail++; $display("FAIL random_stable got %b/%h want 1/%h", i1.data_vld, i1.data, held); end
            end
            i1.data_rdy = 1'($urandom_range(0, 1));
            if (i1.data_vld && i1.data_rdy) begin
                n_chk++; if (i1.data !== pl(7, exp_seq)) begin n_fail++; $display("FAIL random_seq got %h want %h", i1.data, pl(7, exp_seq)); end
                exp_seq++;
            end
            stalled = i1.data_vld && !i1.data_rdy;
            held = i1.data;
            tick;
        end
        n_chk++; if (exp_seq != 1000 || cnt1 !== 32'd1000 || done1 !== 1'b1) begin n_fail++; $display("FAIL random_total got %0d/%0d/%b want 1000/1000/1", exp_seq, cnt1, done1); end
    endtask

    task automatic test_gap;
        int pulses = 0, last = 0;
        i2.data_rdy = 1;
        st2 = 1; tick; st2 = 0;
        for (int c = 0; c < 30; c++) begin
            if (i2.data_vld) begin
                n_chk++; if (i2.data !== pl(2, pulses)) begin n_fail++; $display("FAIL gap_data got %h want %h", i2.data, pl(2, pulses)); end
                if (pulses > 0) begin
                    n_chk++; if (c - last != 3) begin n_fail++; $display("FAIL gap_spacing got %0d want 3", c - last); end
                end
                last = c;
                pulses++;
            end
            tick;
        end
        n_chk++; if (pulses != 6 || done2 !== 1'b1 || cnt2 !== 32'd6) begin n_fail++; $display("FAIL gap_total got %0d/%b/%0d want 6/1/6", pulses, done2, cnt2); end
    endtask

    task automatic test_reset_mid;
        i0.data_rdy = 1;
        st0 = 1; tick; st0 = 0;
        for (int k = 0; k < 20 && cnt0 !== 32'd4; k++) tick;
        n_chk++; if (cnt0 !== 32'd4 || i0.data_vld !== 1'b1) begin n_fail++; $display("FAIL mid_reach got %0d/%b want 4/1", cnt0, i0.data_vld); end
        #2 rst_n = 0;
        #1;
        n_chk++; if ({i0.data_vld, busy0, done0} !== 3'b000 || cnt0 !== 32'd0 || i0.data !== 64'h0) begin n_fail++; $display("FAIL mid_async got %b/%0d/%h want 000/0/0", {i0.data_vld, busy0, done0}, cnt0, i0.data); end
        @(negedge clk) rst_n = 1;
        repeat (3) tick;
        n_chk++; if ({i0.data_vld, busy0, done0} !== 3'b000) begin n_fail++; $display("FAIL mid_idle got %b want 000", {i0.data_vld, busy0, done0}); end
        st0 = 1; tick; st0 = 0;
        tick;
        n_chk++; if (i0.data_vld !== 1'b1 || i0.data !== pl(3, 0)) begin n_fail++; $display("FAIL mid_restart got %b/%h want 1/%h", i0.data_vld, i0.data, pl(3, 0)); end
        for (int k = 0; k < 30 && done0 !== 1'b1; k++) tick;
        n_chk++; if (done0 !== 1'b1 || cnt0 !== 32'd10) begin n_fail++; $display("FAIL mid_done got %b/%0d want 1/10", done0, cnt0); end
    endtask

    task automatic test_zero;
        logic saw_vld = 0;
        i3.data_rdy = 1;
        for (int r = 0; r < 2; r++) begin
            saw_vld = 0;
            st3 = 1; tick; st3 = 0;
            n_chk++; if (busy3 !== 1'b1 || done3 !== 1'b0) begin n_fail++; $display("FAIL zero_run%0d got %b/%b want 1/0", r, busy3, done3); end
            for (int k = 0; k < 3 && done3 !== 1'b1; k++) begin
                saw_vld = saw_vld | i3.data_vld;
                tick;
            end
            n_chk++; if (done3 !== 1'b1 || saw_vld !== 1'b0 || cnt3 !== 32'd0) begin n_fail++; $display("FAIL zero_done%0d got %b/%b/%0d want 1/0/0", r, done3, saw_vld, cnt3); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_random;
        test_gap;
        test_reset_mid;
        test_zero;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_tx.md
CPU_TX -- requirements
Module: cpu_tx

Interface
REQ-001 SHALL have parameter: CPU_IDX, 0, CPU index embedded in every payload (0..255).
REQ-002 SHALL have parameter: TRANSACTION_NB, 10, number of transactions sent per run (0..2^32-1).
REQ-003 SHALL have parameter: FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter: GAP_CYCLES, 0, minimum idle cycles between generator pushes.
REQ-005 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port: start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-008 SHALL have port: data_rdy  input  1  NOC ready to accept.
REQ-009 SHALL have port: data_vld  output  1  payload valid toward NOC.
REQ-010 SHALL have port: data  output  64  payload toward NOC.
REQ-011 SHALL have port: busy  output  1  high in RUN or DRAIN.
REQ-012 SHALL have port: done  output  1  high in DONE.
REQ-013 SHALL have port: sent_count  output  32  handshakes completed in the current run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-015 SHALL go IDLE->RUN or DONE->RUN on the clock edge where start=1; start ignored in RUN/DRAIN.
REQ-016 SHALL, on entering RUN, clear gen_cnt, sent_count, gap counter, and FIFO pointers.
REQ-017 SHALL, in RUN, push one payload per cycle when gen_cnt<TRANSACTION_NB, FIFO not full, and gap counter=0; each push increments gen_cnt and loads the gap counter with GAP_CYCLES.
REQ-018 SHALL decrement the gap counter by 1 per cycle while nonzero.
REQ-019 SHALL form each payload as {CPU_IDX[7:0], 8'hA5, 16'h0000, gen_cnt[31:0]} at the time of push.
REQ-020 SHALL go RUN->DRAIN on the cycle after gen_cnt reaches TRANSACTION_NB, including immediately when TRANSACTION_NB=0.
REQ-021 SHALL go DRAIN->DONE on the cycle the FIFO is empty and no handshake is pending.
REQ-022 SHALL drive data_vld = FIFO not empty and data = FIFO head; there is no bypass path, so a push into an empty FIFO raises data_vld on the next cycle.
REQ-023 SHALL pop the head on every cycle with data_vld=1 and data_rdy=1 (handshake) and increment sent_count.
REQ-024 SHALL hold data_vld high and data unchanged while data_vld=1 and data_rdy=0.
REQ-025 SHALL, on a simultaneous push and pop, update occupancy by net zero; when full, push is blocked that cycle even if a pop occurs.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH and use an extra pointer bit for full/empty discrimination.
REQ-027 SHALL keep payload order identical to generation order (seq 0,1,2,...).
REQ-028 SHALL keep done=1 and sent_count=TRANSACTION_NB in DONE until the next start.
REQ-029 SHALL never present data_vld=1 in IDLE or DONE.

Reset
REQ-030 SHALL, on rst_n=0, immediately (without clk) force state IDLE, data_vld=0, data=0, busy=0, done=0, sent_count=0, and clear the FIFO pointers, FIFO storage, gen_cnt, and gap counter.
REQ-031 SHALL abandon any in-flight run when reset asserts mid-operation; after release it remains in IDLE until start.
REQ-032 SHALL ignore start while rst_n=0; rst_n deassertion is synchronized to clk outside this block.

Verification
REQ-033 SHALL cover: CPU_IDX=3, TRANSACTION_NB=10, data_rdy=1 constant, start at cycle 5 -> data_vld first at cycle 7, ten payloads 0x03A5_0000_0000_0000..0x03A5_0000_0000_0009 on consecutive cycles, done=1, sent_count=10.
REQ-034 SHALL cover: FIFO_DEPTH=4, data_rdy=0 for 20 cycles after start -> exactly 4 pushes, data_vld high with data held at seq 0; on data_rdy=1 all 10 drain in order.
REQ-035 SHALL cover: random data_rdy (50%) over 1000 transactions -> no drops, no duplicates, strictly increasing seq, data stable whenever stalled.
REQ-036 SHALL cover: GAP_CYCLES=2, data_rdy=1 -> pushes spaced 3 cycles apart; data_vld pulses 1 of every 3 cycles.
REQ-037 SHALL cover: rst_n=0 asserted at transaction 4 of 10 -> data_vld=0 with no clock edge; after release and a new start, seq restarts at 0 and sent_count ends at 10.
REQ-038 SHALL cover: TRANSACTION_NB=0, start -> no data_vld, done=1 within 3 cycles; a second start in DONE reruns the same sequence.
